jfpjc_quant_scheduler: RTL and testbench
========================================

// Module: jfpjc_quant_scheduler
// PURPOSE
//   Round-robin scheduler that shares the single quantizer among the NUM_DCT
//   DCT engines of the jfpjc compressor. When a DCT engine has a finished
//   8x8 block in its back buffer, this block reads its 64 coefficients out in
//   raster or zigzag order and streams them to the quantizer with an index tag.
//   It then releases the buffer back to that DCT engine.
// PARAMETERS
//   NUM_DCT   5   number of DCT engines (requesters), 2..8
//   ZIGZAG    0   1: fetch in JPEG zigzag order; 0: raster order
// PORTS
//   clock            in   1          system clock; all logic on posedge
//   reset            in   1          synchronous, active-high
//   enable           in   1          0: finish current block, grant no new ones
//   block_ready      in   NUM_DCT    level; DCT i holds a full block
//   block_release    out  NUM_DCT    1-cycle pulse; buffer of DCT i freed
//   fetch_en         out  1          read strobe to the selected DCT output mem
//   fetch_sel        out  3          index of the granted DCT
//   fetch_addr       out  6          coefficient address in the DCT output mem
//   coef_in          in   16         signed read data; valid 1 cycle after fetch_en
//   quant_ready      in   1          quantizer can accept issues
//   quant_valid      out  1          quant_coef/quant_tag valid this cycle
//   quant_coef       out  16         signed coefficient to the quantizer
//   quant_table_addr out  6          quantization table index (= scan position)
//   quant_tag        out  8          {block_seq[1:0], scan_pos[5:0]}
//   busy             out  1          1 whenever state != IDLE
// BEHAVIOUR
//   Reset: all outputs 0. state=IDLE, rr_ptr=NUM_DCT-1, block_seq=0, scan_pos=0,
//     in-flight data discarded. Reset mid-block emits no release pulse; the DCT
//     keeps block_ready high and the block is re-fetched from scan_pos 0.
//   FSM: IDLE -> FETCH -> DRAIN -> RELEASE -> IDLE.
//   IDLE: if enable && |block_ready, grant the first i with block_ready[i],
//     searching cyclically from rr_ptr+1. Set rr_ptr=i and fetch_sel=i, then go to FETCH.
//     Simultaneous requests are resolved only by this cyclic search.
//   FETCH: each cycle with quant_ready=1 pulses fetch_en with
//     fetch_addr = ZIGZAG ? zz_rom[scan_pos] : scan_pos, then increments scan_pos.
//     With quant_ready=0: no issue, and scan_pos/fetch_addr hold.
//     Leaves for DRAIN in the cycle the issue at scan_pos=63 happens.
//   Pipeline: fetch at cycle t -> coef_in sampled at t+1 -> quant_valid,
//     quant_coef, quant_tag, quant_table_addr registered, high for exactly
//     cycle t+2. This gives 2-cycle issue-to-output latency.
//     quant_ready gates issue only; the quantizer guarantees 2 entries of slack.
//   DRAIN: 1 cycle. Captures the last coef_in, then goes to RELEASE.
//   RELEASE: pulses block_release[fetch_sel] for 1 cycle, the same cycle the last
//     quant_valid is high. Increments block_seq (mod 4), clears scan_pos,
//     returns to IDLE. The requester must drop block_ready[i] by the next cycle.
//   First fetch_en comes 1 cycle after grant. Back-to-back blocks have a
//     minimum gap of 3 cycles between the last fetch of one block and the first
//     fetch of the next.
//   quant_table_addr = scan_pos of the coefficient, so the table is stored in scan order.
//   block_ready bits >= NUM_DCT are ignored. enable is sampled only in IDLE.
//   zz_rom: standard JPEG zigzag, 0,1,8,16,9,2,3,10,17,24,...,55,62,63.
// TESTING
//   1 block_ready=5'b00100, quant_ready=1 -> fetch_sel=2, fetch_addr 0..63 on 64
//     consecutive cycles. quant_valid high 64 consecutive cycles starting 2 after
//     the first fetch, with tags 0x00..0x3F and coef_in passed through unchanged.
//     One block_release=5'b00100 pulse.
//   2 all five block_ready high after reset, held until released -> grants in
//     order 0,1,2,3,4. quant_tag[7:6] per block = 0,1,2,3,0.
//   3 quant_ready low for cycles 10..14 of a block -> no fetch_en in those
//     cycles. Exactly 64 quant_valid, with no tag repeated or skipped.
//   4 ZIGZAG=1 -> fetch_addr starts 0,1,8,16,9,2,3,10 and ends 63. quant_tag[5:0]
//     and quant_table_addr run 0..63.
//   5 reset pulsed after 30 fetches -> the following cycle has all outputs 0 and
//     no block_release. After reset the same DCT is regranted and fetch_addr
//     restarts at 0.
//   6 enable dropped mid-block with DCT1 and DCT3 ready -> the current block
//     completes and is released, busy falls, and no further grant occurs until
//     enable=1.

Source files
------------

// File: rtl/jfpjc_quant_scheduler.sv
// Round-robin scheduler sharing one quantizer among NUM_DCT DCT engines: streams each
// finished 8x8 block in raster or zigzag order with a tag, then frees the DCT's buffer.
module jfpjc_quant_scheduler #(
  parameter int NUM_DCT = 5,
  parameter bit ZIGZAG  = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_DCT-1:0] block_ready,
  output logic [NUM_DCT-1:0] block_release,
  output logic               fetch_en,
  output logic [2:0]         fetch_sel,
  output logic [5:0]         fetch_addr,
  input  logic [15:0]        coef_in,
  input  logic               quant_ready,
  output logic               quant_valid,
  output logic [15:0]        quant_coef,
  output logic [5:0]         quant_table_addr,
  output logic [7:0]         quant_tag,
  output logic               busy
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_DRAIN   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [5:0] ZZ_ROM [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t               r_state;
  state_t               w_next_state;
  logic [2:0]           r_rr_ptr;
  logic [2:0]           r_sel;
  logic [5:0]           r_scan_pos;
  logic [1:0]           r_block_seq;
  logic                 r_issue_v;
  logic [7:0]           r_issue_tag;
  logic                 r_quant_valid;
  logic [15:0]          r_quant_coef;
  logic [7:0]           r_quant_tag;
  logic [NUM_DCT-1:0]   r_release;
  logic                 w_issue;
  logic                 w_grant;
  logic                 w_found;
  logic [2:0]           w_grant_idx;
  logic [3:0]           w_sum;
  logic [7:0]           w_req;

  // Cyclic search for the first requester after the last one granted
  always_comb begin
    w_req       = 8'(block_ready);
    w_found     = 1'b0;
    w_grant_idx = 3'd0;
    w_sum       = 4'd0;
    for (int k = 1; k <= NUM_DCT; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(NUM_DCT)) begin
        w_sum = w_sum - 4'(NUM_DCT);
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && w_req[w_sum[2:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_sum[2:0];
      end else begin
        w_found     = w_found;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_found) begin
          w_grant      = 1'b1;
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH: begin
        if (quant_ready) begin
          w_issue = 1'b1;
          if (r_scan_pos == 6'd63) begin
            w_next_state = S_DRAIN;
          end else begin
            w_next_state = S_FETCH;
          end
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DRAIN:   w_next_state = S_RELEASE;
      S_RELEASE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant bookkeeping, scan position and per-block sequence number
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= 3'(NUM_DCT - 1);
      r_sel       <= 3'd0;
      r_scan_pos  <= 6'd0;
      r_block_seq <= 2'd0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_grant_idx;
        r_sel    <= w_grant_idx;
      end
      if (w_issue) begin
        r_scan_pos <= r_scan_pos + 6'd1;
      end else if (r_state == S_RELEASE) begin
        r_scan_pos <= 6'd0;
      end
      if (r_state == S_RELEASE) begin
        r_block_seq <= r_block_seq + 2'd1;
      end
    end
  end

  // Issue -> read-data -> quantizer output pipeline; the release pulse lines up with the last output
  always_ff @(posedge clock) begin
    if (reset) begin
      r_issue_v     <= 1'b0;
      r_issue_tag   <= 8'd0;
      r_quant_valid <= 1'b0;
      r_quant_coef  <= 16'd0;
      r_quant_tag   <= 8'd0;
      r_release     <= '0;
    end else begin
      r_issue_v     <= w_issue;
      r_issue_tag   <= {r_block_seq, r_scan_pos};
      r_quant_valid <= r_issue_v;
      r_quant_coef  <= r_issue_v ? coef_in : 16'd0;
      r_quant_tag   <= r_issue_v ? r_issue_tag : 8'd0;
      r_release     <= (r_state == S_DRAIN) ? ({{(NUM_DCT-1){1'b0}}, 1'b1} << r_sel) : '0;
    end
  end

  assign fetch_en         = w_issue;
  assign fetch_sel        = r_sel;
  assign fetch_addr       = ZIGZAG ? ZZ_ROM[r_scan_pos] : r_scan_pos;
  assign quant_valid      = r_quant_valid;
  assign quant_coef       = r_quant_coef;
  assign quant_tag        = r_quant_tag;
  assign quant_table_addr = r_quant_tag[5:0];
  assign block_release    = r_release;
  assign busy             = (r_state != S_IDLE);
endmodule

// File: tb/tb_jfpjc_quant_scheduler.sv
// Scoreboard bench: a raster and a zigzag instance share stimulus; expected quantizer
// outputs are queued at each fetch and popped when quant_valid appears.
module tb_jfpjc_quant_scheduler;
  localparam int N = 5;

  logic clk = 1'b0;
  logic reset, enable, quant_ready;
  logic [N-1:0] block_ready;
  logic fe [2];
  logic [5:0] fa [2];
  logic [2:0] fs [2];
  logic qv [2];
  logic [15:0] qc [2];
  logic [5:0] qta [2];
  logic [7:0] qt [2];
  logic [N-1:0] br [2];
  logic bsy [2];
  logic [15:0] coef [2];

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] zz [64];
  logic [23:0] sbq [2][$];
  int pos [2], seq [2], rr [2], msel [2], rel_wait [2], nvalid [2];
  bit prev_busy [2];
  logic [N-1:0] prev_ready;
  bit prev_en, prev_rst;
  int n_fetch = 0;
  int grants [$];
  logic [5:0] zz_log [$];
  bit saw_rel;

  always #5 clk = ~clk;

  jfpjc_quant_scheduler #(.NUM_DCT(N), .ZIGZAG(1'b0)) dut_raster (
    .clock(clk), .reset(reset), .enable(enable), .block_ready(block_ready),
    .block_release(br[0]), .fetch_en(fe[0]), .fetch_sel(fs[0]), .fetch_addr(fa[0]),
    .coef_in(coef[0]), .quant_ready(quant_ready), .quant_valid(qv[0]), .quant_coef(qc[0]),
    .quant_table_addr(qta[0]), .quant_tag(qt[0]), .busy(bsy[0]));

  jfpjc_quant_scheduler #(.NUM_DCT(N), .ZIGZAG(1'b1)) dut_zigzag (
    .clock(clk), .reset(reset), .enable(enable), .block_ready(block_ready),
    .block_release(br[1]), .fetch_en(fe[1]), .fetch_sel(fs[1]), .fetch_addr(fa[1]),
    .coef_in(coef[1]), .quant_ready(quant_ready), .quant_valid(qv[1]), .quant_coef(qc[1]),
    .quant_table_addr(qta[1]), .quant_tag(qt[1]), .busy(bsy[1]));

  function automatic logic [15:0] coef_of(input logic [2:0] s, input logic [5:0] a);
    return 16'(int'(s) * 4099 - int'(a) * 311 + 7);
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // DCT output memories: registered read, data valid the cycle after fetch_en
  always @(posedge clk) begin
    if (fe[0]) coef[0] <= coef_of(fs[0], fa[0]);
    if (fe[1]) coef[1] <= coef_of(fs[1], fa[1]);
  end

  task automatic mon(input int u);
    logic [N-1:0] exp_rel;
    logic [5:0] a;
    logic [23:0] e;
    int g;
    exp_rel = (rel_wait[u] == 1) ? N'(1 << msel[u]) : '0;
    if (rel_wait[u] > 0) rel_wait[u]--;
    if (prev_rst) begin
      check("rst_fetch", {fe[u], fa[u], fs[u], bsy[u]}, 32'd0);
      check("rst_quant", {qv[u], qc[u], qta[u], qt[u]}, 32'd0);
    end
    if (br[u] != '0 || exp_rel != '0) check("release", br[u], exp_rel);
    if (qv[u]) begin
      if (sbq[u].size() == 0) begin
        check("spurious_valid", qv[u], 1'b0);
      end else begin
        e = sbq[u].pop_front();
        check("tag", qt[u], e[23:16]);
        check("coef", qc[u], e[15:0]);
        check("table_addr", qta[u], e[21:16]);
      end
      nvalid[u]++;
    end
    if (exp_rel != '0) begin
      check("valid_cnt", nvalid[u], 64);
      nvalid[u] = 0;
      seq[u] = (seq[u] + 1) % 4;
    end
    if (!prev_busy[u] && bsy[u]) begin
      g = rr_pick(rr[u], prev_ready);
      check("grant_en", prev_en, 1'b1);
      check("fetch_sel", fs[u], g);
      msel[u] = g;
      rr[u] = g;
      pos[u] = 0;
      if (u == 0) grants.push_back(int'(fs[u]));
      if (u == 1) zz_log.delete();
    end else if (!prev_busy[u] && !bsy[u] && !prev_rst && prev_en && prev_ready != '0) begin
      check("grant_miss", bsy[u], 1'b1);
    end
    if (fe[u]) begin
      check("fetch_in_block", pos[u] < 64, 1'b1);
      a = (u == 1) ? zz[pos[u] & 63] : 6'(pos[u]);
      check("fetch_addr", fa[u], a);
      sbq[u].push_back({2'(seq[u]), 6'(pos[u]), coef_of(3'(msel[u]), a)});
      if (pos[u] == 63) rel_wait[u] = 2;
      pos[u]++;
      if (u == 0) n_fetch++;
      if (u == 1) zz_log.push_back(fa[u]);
    end
    if (!quant_ready && bsy[u]) check("no_issue", fe[u], 1'b0);
    if (reset) begin
      sbq[u].delete();
      pos[u] = 0; seq[u] = 0; rr[u] = N - 1; rel_wait[u] = 0; nvalid[u] = 0;
    end
    prev_busy[u] = bsy[u];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
    prev_ready = block_ready;
    prev_en = enable;
    prev_rst = reset;
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (br[0] != '0) begin
      block_ready = block_ready & ~br[0];
      saw_rel = 1'b1;
    end
  endtask

  task automatic wait_rel(input string tag);
    int n = 0;
    saw_rel = 1'b0;
    while (!saw_rel && n < 400) begin step(); n++; end
    check({tag, "_release_timeout"}, saw_rel, 1'b1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!bsy[0] && n < 100) begin step(); n++; end
    check({tag, "_grant_timeout"}, bsy[0], 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] zz_head [8];
    int p, base, n, prev;
    zz_head = '{6'd0, 6'd1, 6'd8, 6'd16, 6'd9, 6'd2, 6'd3, 6'd10};
    p = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[p] = 6'(r * 8 + s - r); p++; end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[p] = 6'(r * 8 + s - r); p++; end
      end
    end
    for (int u = 0; u < 2; u++) begin
      pos[u] = 0; seq[u] = 0; rr[u] = N - 1; msel[u] = 0; rel_wait[u] = 0; nvalid[u] = 0; prev_busy[u] = 1'b0;
    end
    reset = 1'b1; enable = 1'b1; quant_ready = 1'b1; block_ready = '0; saw_rel = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    block_ready = 5'b00100;
    wait_rel("t1");
    repeat (3) step();
    check("t1_grants", grants.size(), 1);
    check("t1_sel", grants[grants.size() - 1], 2);
    check("zz_len", zz_log.size(), 64);
    for (int i = 0; i < 8; i++) check("zz_head", zz_log[i], zz_head[i]);
    check("zz_tail", zz_log[zz_log.size() - 1], 63);

    pulse_reset();
    block_ready = 5'b11111;
    base = grants.size();
    repeat (5) wait_rel("t2");
    check("t2_grants", grants.size(), base + 5);
    for (int i = 0; i < 5; i++) check("t2_order", grants[base + i], i);

    block_ready = 5'b00010;
    wait_busy("t3");
    repeat (10) step();
    quant_ready = 1'b0;
    repeat (5) step();
    quant_ready = 1'b1;
    wait_rel("t3");

    block_ready = 5'b01000;
    wait_busy("t5");
    base = n_fetch;
    n = 0;
    while (n_fetch < base + 30 && n < 200) begin step(); n++; end
    prev = grants[grants.size() - 1];
    check("t5_sel", prev, 3);
    pulse_reset();
    wait_rel("t5");
    check("t5_regrant", grants[grants.size() - 1], prev);

    block_ready = 5'b01010;
    wait_busy("t6");
    repeat (20) step();
    enable = 1'b0;
    wait_rel("t6a");
    check("t6_first", grants[grants.size() - 1], 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_hold", bsy[0], 1'b0);
    end
    enable = 1'b1;
    wait_rel("t6b");
    check("t6_second", grants[grants.size() - 1], 3);

    repeat (5) step();
    check("sb_empty_raster", sbq[0].size(), 0);
    check("sb_empty_zigzag", sbq[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
